// File: rtl/pq_dev.sv
// pq_dev: sorted-register priority queue, min key on kvo, FIFO among equal keys
module pq_dev #(
  parameter int DEPTH = 8,
  parameter int KEY_W = 8,
  parameter int VAL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_W+VAL_W-1:0] kvi,
  input  logic                   enq,
  input  logic                   deq,
  output logic                   full,
  output logic                   busy,
  output logic                   empty,
  output logic [KEY_W+VAL_W-1:0] kvo
);
  localparam int W  = KEY_W + VAL_W;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, UPDATE} state_t;
  state_t         r_state, w_next;
  logic           r_enq, r_deq;
  logic [W-1:0]   r_kv;
  logic [W-1:0]   r_mem  [DEPTH];
  logic [W-1:0]   w_base [DEPTH];
  logic [W-1:0]   w_new  [DEPTH];
  logic [DEPTH-1:0] w_le;
  logic [CW-1:0]  r_cnt, w_n;
  logic           w_acc_enq, w_acc_deq, w_acc;
  assign busy      = (r_state == UPDATE);
  assign kvo       = r_mem[0];
  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CW'(DEPTH));
  // enq with deq on a non-empty queue is a replace, so fullness does not block it
  assign w_acc_enq = enq & (deq | ~full);
  assign w_acc_deq = deq & ~empty;
  assign w_acc     = (r_state == IDLE) & (w_acc_enq | w_acc_deq);
  assign w_n       = r_cnt - CW'(r_deq);
  always_comb begin
    w_next = r_state;
    if (r_state == UPDATE) w_next = IDLE;
    else if (w_acc) w_next = UPDATE;
  end
  // shift out the head first, then insert after every entry with key <= new key
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) w_base[i] = r_deq ? r_mem[i+1] : r_mem[i];
    w_base[DEPTH-1] = r_deq ? '0 : r_mem[DEPTH-1];
    for (int i = 0; i < DEPTH; i++)
      w_le[i] = (CW'(i) < w_n) && (w_base[i][W-1:VAL_W] <= r_kv[W-1:VAL_W]);
    w_new[0] = !r_enq ? w_base[0] : w_le[0] ? w_base[0] : r_kv;
    for (int i = 1; i < DEPTH; i++)
      w_new[i] = !r_enq ? w_base[i] : w_le[i] ? w_base[i] : w_le[i-1] ? r_kv : w_base[i-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_enq   <= 1'b0;
      r_deq   <= 1'b0;
      r_kv    <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_enq <= w_acc_enq;
        r_deq <= w_acc_deq;
        r_kv  <= kvi;
      end
      if (r_state == UPDATE) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_new[i];
        r_cnt <= w_n + CW'(r_enq);
      end
    end
  end
endmodule

// File: tb/tb_pq_dev.sv
// tb_pq_dev: table vectors, corner sequences and a queue-model random run for pq_dev
module tb_pq_dev;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, enq = 0, deq = 0;
  logic [15:0] kvi = '0, kvo;
  logic full, busy, empty;
  logic b1;
  int errs = 0, checks = 0;
  logic [15:0] mq[$];
  typedef struct {
    bit e; bit d; logic [15:0] kv;
    logic [15:0] x_kvo; bit x_busy; bit x_empty; bit x_full;
  } vec_t;
  vec_t tv[10];

  pq_dev #(.DEPTH(DEPTH), .KEY_W(8), .VAL_W(8)) dut (
    .clk(clk), .rst(rst), .kvi(kvi), .enq(enq), .deq(deq),
    .full(full), .busy(busy), .empty(empty), .kvo(kvo));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  // present a request for one edge, record busy after it, return after the following edge
  task automatic op(input bit e, input bit d, input logic [15:0] kv);
    @(negedge clk); enq = e; deq = d; kvi = kv;
    @(negedge clk); enq = 0; deq = 0; b1 = busy;
    @(negedge clk);
  endtask

  function automatic bit m_op(input bit e, input bit d, input logic [15:0] kv);
    bit de, en;
    int p;
    de = d && mq.size() > 0;
    en = e && (d || mq.size() < DEPTH);
    if (de) void'(mq.pop_front());
    if (en) begin
      p = 0;
      while (p < mq.size() && mq[p][15:8] <= kv[15:8]) p++;
      mq.insert(p, kv);
    end
    return de || en;
  endfunction

  task automatic reset_all();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    mq.delete();
  endtask

  initial begin
    tv[0] = '{1, 0, 16'h05AA, 16'h05AA, 1, 0, 0};
    tv[1] = '{1, 0, 16'h02BB, 16'h02BB, 1, 0, 0};
    tv[2] = '{1, 0, 16'h09CC, 16'h02BB, 1, 0, 0};
    tv[3] = '{1, 0, 16'h02DD, 16'h02BB, 1, 0, 0};
    tv[4] = '{0, 1, 16'h0000, 16'h02DD, 1, 0, 0};
    tv[5] = '{0, 1, 16'h0000, 16'h05AA, 1, 0, 0};
    tv[6] = '{0, 1, 16'h0000, 16'h09CC, 1, 0, 0};
    tv[7] = '{0, 1, 16'h0000, 16'h0000, 1, 1, 0};
    tv[8] = '{0, 1, 16'h0000, 16'h0000, 0, 1, 0};
    tv[9] = '{1, 0, 16'h0311, 16'h0311, 1, 0, 0};
    repeat (2) @(negedge clk);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset busy", busy, 0);
    chk("reset kvo", kvo, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      op(tv[i].e, tv[i].d, tv[i].kv);
      chk($sformatf("tbl%0d busy pulse", i), b1, tv[i].x_busy);
      chk($sformatf("tbl%0d busy", i), busy, 0);
      chk($sformatf("tbl%0d kvo", i), kvo, tv[i].x_kvo);
      chk($sformatf("tbl%0d empty", i), empty, tv[i].x_empty);
      chk($sformatf("tbl%0d full", i), full, tv[i].x_full);
    end
    // back-to-back request while busy is ignored
    reset_all();
    enq = 1; kvi = 16'h0344;
    @(negedge clk);
    chk("lat busy after N", busy, 1);
    kvi = 16'h0155;
    @(negedge clk);
    chk("lat busy after N+1", busy, 0);
    chk("lat kvo", kvo, 16'h0344);
    enq = 0;
    @(negedge clk);
    chk("lat no second pulse", busy, 0);
    op(0, 1, 0);
    chk("lat count was 1", empty, 1);
    // full, ignored enq, replace while full
    reset_all();
    for (int k = 1; k <= DEPTH; k++) op(1, 0, {8'(k), 8'(k)});
    chk("full flag", full, 1);
    chk("full head", kvo, 16'h0101);
    op(1, 0, 16'h0077);
    chk("full enq ignored", b1, 0);
    chk("full enq kvo", kvo, 16'h0101);
    op(1, 1, 16'h0077);
    chk("full replace kvo", kvo, 16'h0077);
    chk("full replace full", full, 1);
    // replace on a partial queue
    reset_all();
    op(1, 0, 16'h0441);
    op(1, 0, 16'h0772);
    op(1, 1, 16'h0663);
    chk("repl kvo", kvo, 16'h0663);
    op(0, 1, 0);
    chk("repl second", kvo, 16'h0772);
    chk("repl not empty", empty, 0);
    op(0, 1, 0);
    chk("repl count 2", empty, 1);
    // asynchronous reset in the middle of UPDATE
    reset_all();
    @(negedge clk); enq = 1; kvi = 16'h0512;
    @(posedge clk); #1;
    chk("rst mid busy", busy, 1);
    rst = 1; #1;
    chk("rst mid busy clr", busy, 0);
    chk("rst mid empty", empty, 1);
    chk("rst mid full", full, 0);
    chk("rst mid kvo", kvo, 0);
    @(negedge clk); enq = 0; rst = 0;
    op(1, 0, 16'h0813);
    chk("rst after enq pulse", b1, 1);
    chk("rst after kvo", kvo, 16'h0813);
    // randomized run against the queue model
    reset_all();
    repeat (300) begin
      bit e, d, acc;
      logic [15:0] kv;
      e = ($urandom % 100) < 60;
      d = ($urandom % 100) < 45;
      kv = {8'($urandom_range(0, 7)), 8'($urandom)};
      acc = m_op(e, d, kv);
      op(e, d, kv);
      chk("rnd busy pulse", b1, acc);
      chk("rnd kvo", kvo, mq.size() > 0 ? mq[0] : 16'h0);
      chk("rnd empty", empty, mq.size() == 0);
      chk("rnd full", full, mq.size() == DEPTH);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
